// File: rtl/axis_trailer_strip.sv
// Strips a fixed-width trailer (e.g. a timestamp) from the tail of every AXI4-Stream packet
// and presents it as a one-cycle side-band word alongside the shortened payload.
module axis_trailer_strip #(
    parameter int DATA_WIDTH    = 8,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int TRAILER_WIDTH = 32,
    parameter int USER_WIDTH    = 1,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,

    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,

    output logic [TRAILER_WIDTH-1:0] trailer_tdata,
    output logic                     trailer_valid,
    output logic                     trailer_error
);

    localparam int N     = TRAILER_WIDTH / DATA_WIDTH;
    localparam int DEPTH = N + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((TRAILER_WIDTH % DATA_WIDTH) != 0 || N < 1) begin : g_bad_trailer_width
        $error("TRAILER_WIDTH must be a non-zero multiple of DATA_WIDTH");
    end

    typedef enum logic {StFill, StClose} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_d [DEPTH];
    logic [KEEP_WIDTH-1:0]    keep_q [DEPTH];
    logic [KEEP_WIDTH-1:0]    keep_d [DEPTH];
    logic [USER_WIDTH-1:0]    user_q [DEPTH];
    logic [USER_WIDTH-1:0]    user_d [DEPTH];
    logic [TRAILER_WIDTH-1:0] trailer_q, trailer_d;
    logic                     tvalid_q, tvalid_d;
    logic                     terr_q, terr_d;

    logic                     in_hs, out_hs;
    logic [CW-1:0]            wr_idx;
    logic [USER_WIDTH-1:0]    user_or;
    logic                     keep_bad;

    always_comb begin
        user_or  = user_q[0];
        keep_bad = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            user_or  = user_or | user_q[i];
            keep_bad = keep_bad | (keep_q[i] != {KEEP_WIDTH{1'b1}});
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        keep_d    = keep_q;
        user_d    = user_q;
        trailer_d = trailer_q;
        tvalid_d  = 1'b0;
        terr_d    = 1'b0;
        in_hs     = 1'b0;
        out_hs    = 1'b0;
        wr_idx    = count_q;

        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = data_q[0];
        m_axis_tkeep  = keep_q[0];
        m_axis_tuser  = user_q[0];

        unique case (state_q)
            StFill: begin
                // A full buffer means the oldest beat cannot be part of the trailer.
                s_axis_tready = (count_q != FULL) || m_axis_tready;
                m_axis_tvalid = (count_q == FULL);
                in_hs         = s_axis_tvalid && s_axis_tready;
                out_hs        = m_axis_tvalid && m_axis_tready;

                if (out_hs) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        data_d[i] = data_q[i+1];
                        keep_d[i] = keep_q[i+1];
                        user_d[i] = user_q[i+1];
                    end
                    wr_idx = count_q - CW'(1);
                end

                if (in_hs) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CW'(i) == wr_idx) begin
                            data_d[i] = s_axis_tdata;
                            keep_d[i] = s_axis_tkeep;
                            user_d[i] = s_axis_tuser;
                        end
                    end
                end

                count_d = count_q + CW'(in_hs) - CW'(out_hs);

                if (in_hs && s_axis_tlast) begin
                    if (count_d == FULL) begin
                        state_d = StClose;
                    end else begin
                        // Runt: too short to carry payload plus trailer, drop it.
                        count_d = '0;
                        terr_d  = 1'b1;
                    end
                end
            end

            StClose: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = user_or;
                if (m_axis_tready) begin
                    for (int k = 0; k < N; k++) begin
                        if (LITTLE_ENDIAN != 0) begin
                            trailer_d[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k+1];
                        end else begin
                            trailer_d[(N-1-k)*DATA_WIDTH +: DATA_WIDTH] = data_q[k+1];
                        end
                    end
                    tvalid_d = 1'b1;
                    terr_d   = keep_bad;
                    count_d  = '0;
                    state_d  = StFill;
                end
            end

            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFill;
            count_q   <= '0;
            trailer_q <= '0;
            tvalid_q  <= 1'b0;
            terr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
                user_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            trailer_q <= trailer_d;
            tvalid_q  <= tvalid_d;
            terr_q    <= terr_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                keep_q[i] <= keep_d[i];
                user_q[i] <= user_d[i];
            end
        end
    end

    assign trailer_tdata = trailer_q;
    assign trailer_valid = tvalid_q;
    assign trailer_error = terr_q;

endmodule

// File: tb/tb_axis_trailer_strip.sv
// Scoreboard bench for axis_trailer_strip: little- and big-endian instances share one stimulus
// stream; expected payload beats and trailer events are queued when packets are driven.
module tb_axis_trailer_strip;

    localparam int DW = 8;
    localparam int N  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic        m_tready = 1'b1;

    logic        s_tready, s_tready_be;
    logic [7:0]  m_tdata, m_tdata_be;
    logic [0:0]  m_tkeep, m_tkeep_be;
    logic        m_tvalid, m_tvalid_be;
    logic        m_tlast, m_tlast_be;
    logic [0:0]  m_tuser, m_tuser_be;
    logic [31:0] tr_data, tr_data_be;
    logic        tr_valid, tr_valid_be;
    logic        tr_error, tr_error_be;

    always #5 clk = ~clk;

    axis_trailer_strip #(.DATA_WIDTH(DW), .TRAILER_WIDTH(32), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .trailer_tdata(tr_data), .trailer_valid(tr_valid), .trailer_error(tr_error)
    );

    axis_trailer_strip #(.DATA_WIDTH(DW), .TRAILER_WIDTH(32), .LITTLE_ENDIAN(0)) dut_be (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_be), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata_be), .m_axis_tkeep(m_tkeep_be), .m_axis_tvalid(m_tvalid_be),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_be), .m_axis_tuser(m_tuser_be),
        .trailer_tdata(tr_data_be), .trailer_valid(tr_valid_be), .trailer_error(tr_error_be)
    );

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] le;
        logic [31:0] be;
    } tev_t;

    beat_t      exp_q[$];
    tev_t       ev_q[$];
    logic [7:0] pkt_data[$];
    logic       pkt_keep[$];
    logic       pkt_user[$];
    logic [31:0] last_le = '0;
    logic [31:0] last_be = '0;

    int  checks = 0;
    int  errors = 0;
    bit  rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {56'd0, m_tdata}, 64'hFFFF);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("m_tdata", {56'd0, m_tdata}, {56'd0, b.data});
                check("m_tkeep", {63'd0, m_tkeep}, {63'd0, b.keep});
                check("m_tlast", {63'd0, m_tlast}, {63'd0, b.last});
                check("m_tuser", {63'd0, m_tuser}, {63'd0, b.user});
                check("m_tdata_be", {56'd0, m_tdata_be}, {56'd0, b.data});
                check("m_tlast_be", {63'd0, m_tlast_be}, {63'd0, b.last});
            end
        end
        if (!rst && (tr_valid || tr_error)) begin
            if (ev_q.size() == 0) begin
                check("unexpected_trailer_event", {62'd0, tr_valid, tr_error}, 64'd0);
            end else begin
                tev_t t;
                t = ev_q.pop_front();
                check("trailer_valid", {63'd0, tr_valid}, {63'd0, t.v});
                check("trailer_error", {63'd0, tr_error}, {63'd0, t.e});
                check("trailer_tdata_le", {32'd0, tr_data}, {32'd0, t.le});
                check("trailer_tdata_be", {32'd0, tr_data_be}, {32'd0, t.be});
                check("trailer_valid_be", {63'd0, tr_valid_be}, {63'd0, t.v});
            end
        end
    end

    // Derive expected payload and trailer straight from the packet contents.
    task automatic model_pkt();
        int len = pkt_data.size();
        if (len <= N) begin
            ev_q.push_back('{v: 1'b0, e: 1'b1, le: last_le, be: last_be});
        end else begin
            int          pay = len - N;
            logic        u = 1'b0;
            logic        kerr = 1'b0;
            logic [31:0] tle = '0;
            logic [31:0] tbe = '0;
            for (int j = pay - 1; j < len; j++) u |= pkt_user[j];
            for (int i = 0; i < pay; i++) begin
                exp_q.push_back('{data: pkt_data[i], keep: pkt_keep[i], last: (i == pay - 1),
                                  user: (i == pay - 1) ? u : pkt_user[i]});
            end
            for (int k = 0; k < N; k++) begin
                tle[k*8 +: 8]       = pkt_data[pay+k];
                tbe[(N-1-k)*8 +: 8] = pkt_data[pay+k];
                if (!pkt_keep[pay+k]) kerr = 1'b1;
            end
            ev_q.push_back('{v: 1'b1, e: kerr, le: tle, be: tbe});
            last_le = tle;
            last_be = tbe;
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1.
    task automatic send_pkt(input int gap_pct, input bit do_last);
        int len = pkt_data.size();
        if (do_last) model_pkt();
        for (int i = 0; i < len; i++) begin
            int tmo = 0;
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = pkt_data[i];
            s_tkeep  = pkt_keep[i];
            s_tuser  = pkt_user[i];
            s_tlast  = do_last && (i == len - 1);
            forever begin
                @(negedge clk);
                if (s_tready) break;
                tmo++;
                if (tmo > 1000) break;
            end
            if (tmo > 1000) check("s_tready_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic make_pkt(input logic [7:0] base, input int len);
        pkt_data.delete();
        pkt_keep.delete();
        pkt_user.delete();
        for (int i = 0; i < len; i++) begin
            pkt_data.push_back(base + 8'(i));
            pkt_keep.push_back(1'b1);
            pkt_user.push_back(1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_m_tvalid"}, {63'd0, m_tvalid}, 64'd0);
        check({tag, "_m_tlast"}, {63'd0, m_tlast}, 64'd0);
        check({tag, "_trailer_valid"}, {63'd0, tr_valid}, 64'd0);
        check({tag, "_trailer_error"}, {63'd0, tr_error}, 64'd0);
        check({tag, "_trailer_tdata"}, {32'd0, tr_data}, 64'd0);
        check({tag, "_s_tready"}, {63'd0, s_tready}, 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        make_pkt(8'h10, 6);
        send_pkt(0, 1'b1);
        drain();

        make_pkt(8'hA0, 5);
        send_pkt(0, 1'b1);
        drain();

        make_pkt(8'hB0, 4);
        send_pkt(0, 1'b1);
        drain();

        make_pkt(8'h30, 6);
        pkt_user[3] = 1'b1;
        pkt_keep[5] = 1'b0;
        send_pkt(0, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            make_pkt(8'h00, 64);
            for (int i = 0; i < 64; i++) begin
                pkt_data[i] = 8'($urandom);
                pkt_user[i] = ($urandom_range(0, 15) == 0);
            end
            send_pkt(30, 1'b1);
        end
        drain();
        rand_ready = 1'b0;

        make_pkt(8'hC0, 3);
        send_pkt(0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_le = '0;
        last_be = '0;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        make_pkt(8'h50, 6);
        send_pkt(0, 1'b1);
        drain();

        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("events_left", 64'(ev_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
